// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants and helpers, default 800x600@60 Hz on a 40 MHz pixel clock.
// Also used by the pixel-generation stage so both sides agree on geometry.
package vga_timing_pkg;

    localparam int H_W = 11;
    localparam int V_W = 10;
    localparam int H_MAX_TOTAL = 1 << H_W;
    localparam int V_MAX_TOTAL = 1 << V_W;

    localparam int DEF_H_ACTIVE = 800;
    localparam int DEF_H_FP     = 40;
    localparam int DEF_H_SYNC   = 128;
    localparam int DEF_H_BP     = 88;
    localparam int DEF_V_ACTIVE = 600;
    localparam int DEF_V_FP     = 1;
    localparam int DEF_V_SYNC   = 4;
    localparam int DEF_V_BP     = 23;

    // Bit order chosen so the reset value reads {active, vsync, hsync}.
    typedef struct packed {
        logic active;
        logic vsync;
        logic hsync;
    } vga_sync_t;

    function automatic int span_total(input int act, input int fp, input int sync, input int bp);
        return act + fp + sync + bp;
    endfunction

    function automatic int sync_start(input int act, input int fp);
        return act + fp;
    endfunction

    function automatic int sync_end(input int act, input int fp, input int sync);
        return act + fp + sync;
    endfunction

    localparam int DEF_H_TOTAL = span_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
    localparam int DEF_V_TOTAL = span_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

endpackage

// File: rtl/vga_sync_gen_if.sv
// Timing bundle from the sync generator to the pixel stage: counters, syncs, DE and delayed copies.
interface vga_sync_gen_if;
    import vga_timing_pkg::*;

    logic [H_W-1:0] pix_x;
    logic [V_W-1:0] pix_y;
    logic           hsync;
    logic           vsync;
    logic           active;
    logic           line_start;
    logic           frame_start;
    logic           hsync_dly;
    logic           vsync_dly;
    logic           active_dly;

    modport master (
        output pix_x, pix_y, hsync, vsync, active, line_start, frame_start,
        output hsync_dly, vsync_dly, active_dly
    );

    modport slave (
        input pix_x, pix_y, hsync, vsync, active, line_start, frame_start,
        input hsync_dly, vsync_dly, active_dly
    );

endinterface

// File: rtl/vga_delay_line.sv
// Enable-gated shift register of DEPTH stages; DEPTH=0 passes din straight through.
module vga_delay_line #(
    parameter int               WIDTH   = 3,
    parameter int               DEPTH   = 2,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    genvar gi;

    generate
        if (DEPTH == 0) begin : g_bypass
            logic unused_ctrl;
            assign unused_ctrl = &{1'b0, clk, rst_n, en};
            assign dout        = din;
        end else begin : g_shift
            for (gi = 0; gi < DEPTH; gi++) begin : g_stage
                logic [WIDTH-1:0] stage_in;
                logic [WIDTH-1:0] stage_d;
                logic [WIDTH-1:0] stage_q;

                if (gi == 0) begin : g_first
                    assign stage_in = din;
                end else begin : g_next
                    assign stage_in = g_stage[gi-1].stage_q;
                end

                // Stages only advance with the generator so the lag is counted in en-cycles.
                always_comb begin
                    stage_d = stage_q;
                    if (en) begin
                        stage_d = stage_in;
                    end
                end

                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        stage_q <= RST_VAL;
                    end else begin
                        stage_q <= stage_d;
                    end
                end
            end
            assign dout = g_stage[DEPTH-1].stage_q;
        end
    endgenerate

endmodule

// File: rtl/vga_sync_gen.sv
// Parameterised VGA timing generator: pixel counters, sync, DE, line/frame strobes and delayed copies.
// All undelayed outputs are decoded from the next-count values so they align with pix_x/pix_y.
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit H_POL    = 1'b1,
    parameter bit V_POL    = 1'b1,
    parameter int PIPE_DLY = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           en,
    vga_sync_gen_if.master vga
);

    localparam int H_TOTAL = span_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = span_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    generate
        if (H_TOTAL > H_MAX_TOTAL || V_TOTAL > V_MAX_TOTAL) begin : g_bad_size
            $error("vga_sync_gen: H_TOTAL/V_TOTAL exceed the 11/10-bit counters");
        end
        if (PIPE_DLY < 0 || PIPE_DLY > 7) begin : g_bad_dly
            $error("vga_sync_gen: PIPE_DLY must be 0..7");
        end
    endgenerate

    localparam logic [H_W-1:0] H_LAST   = H_W'(H_TOTAL - 1);
    localparam logic [V_W-1:0] V_LAST   = V_W'(V_TOTAL - 1);
    localparam logic [H_W-1:0] H_ACT_C  = H_W'(H_ACTIVE);
    localparam logic [V_W-1:0] V_ACT_C  = V_W'(V_ACTIVE);
    localparam logic [H_W-1:0] HS_START = H_W'(sync_start(H_ACTIVE, H_FP));
    localparam logic [H_W-1:0] HS_END   = H_W'(sync_end(H_ACTIVE, H_FP, H_SYNC));
    localparam logic [V_W-1:0] VS_START = V_W'(sync_start(V_ACTIVE, V_FP));
    localparam logic [V_W-1:0] VS_END   = V_W'(sync_end(V_ACTIVE, V_FP, V_SYNC));

    logic [H_W-1:0] x_d, x_q;
    logic [V_W-1:0] y_d, y_q;
    logic           hsync_d, hsync_q;
    logic           vsync_d, vsync_q;
    logic           active_d, active_q;
    logic           line_start_d, line_start_q;
    logic           frame_start_d, frame_start_q;

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (en) begin
            if (x_q == H_LAST) begin
                x_d = '0;
                y_d = (y_q == V_LAST) ? '0 : y_q + V_W'(1);
            end else begin
                x_d = x_q + H_W'(1);
            end
        end

        // y_d only moves with the x wrap, which keeps vsync line-aligned.
        hsync_d       = ((x_d >= HS_START) && (x_d < HS_END)) ? H_POL : ~H_POL;
        vsync_d       = ((y_d >= VS_START) && (y_d < VS_END)) ? V_POL : ~V_POL;
        active_d      = (x_d < H_ACT_C) && (y_d < V_ACT_C);
        line_start_d  = (x_d == '0);
        frame_start_d = (x_d == '0) && (y_d == '0);
    end

    // Reset parks the counters on the last pixel so the first enabled edge opens a frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q           <= H_LAST;
            y_q           <= V_LAST;
            hsync_q       <= ~H_POL;
            vsync_q       <= ~V_POL;
            active_q      <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            x_q           <= x_d;
            y_q           <= y_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            active_q      <= active_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    vga_sync_t dly_in;
    vga_sync_t dly_out;

    assign dly_in = '{active: active_q, vsync: vsync_q, hsync: hsync_q};

    vga_delay_line #(
        .WIDTH   (3),
        .DEPTH   (PIPE_DLY),
        .RST_VAL ({1'b0, ~V_POL, ~H_POL})
    ) u_delay_line (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .din   (dly_in),
        .dout  (dly_out)
    );

    assign vga.pix_x       = x_q;
    assign vga.pix_y       = y_q;
    assign vga.hsync       = hsync_q;
    assign vga.vsync       = vsync_q;
    assign vga.active      = active_q;
    assign vga.line_start  = line_start_q;
    assign vga.frame_start = frame_start_q;
    assign vga.hsync_dly   = dly_out.hsync;
    assign vga.vsync_dly   = dly_out.vsync;
    assign vga.active_dly  = dly_out.active;

endmodule
